// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
// Holds the state encoding, requester count, select width and a one-hot helper.
package rr_mux8_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// Requester/consumer bundle around the arbiter: requests and source words in, grant/select and muxed word out.
// The arbiter binds the slave side; sources and the consumer sit on the master side.
interface rr_mux8_arbiter_if #(
    parameter int W = 8
);
    import rr_mux8_arbiter_pkg::*;

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] data_in;
    logic [N_REQ-1:0]   gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic [W-1:0]       dout;
    logic               dout_valid;
    logic               done;

    modport master (
        output req, data_in,
        input  gnt, sel, busy, dout, dout_valid, done
    );

    modport slave (
        input  req, data_in,
        output gnt, sel, busy, dout, dout_valid, done
    );

endinterface

// File: rtl/mux_8_to_1_str.sv
// Single-bit 8:1 mux cell built as a three-level tree of 2:1 stages.
// Purely combinational; s[0] selects at the leaf level.
module mux_8_to_1_str (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y
);

    logic [3:0] lvl1;
    logic [1:0] lvl2;

    assign lvl1[0] = s[0] ? d[1] : d[0];
    assign lvl1[1] = s[0] ? d[3] : d[2];
    assign lvl1[2] = s[0] ? d[5] : d[4];
    assign lvl1[3] = s[0] ? d[7] : d[6];

    assign lvl2[0] = s[1] ? lvl1[1] : lvl1[0];
    assign lvl2[1] = s[1] ? lvl1[3] : lvl1[2];

    assign y = s[2] ? lvl2[1] : lvl2[0];

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo 8.
// Zero latency; any=0 means idx is meaningless.
module rr_pick8
    import rr_mux8_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk from the far end back toward ptr so the closest candidate is written last.
    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter/sequencer for a shared 8:1 data mux with a per-tenure hold limit.
// Grant appears one cycle after a request is seen in IDLE, dout one cycle after each GRANT cycle; no backpressure.
module rr_mux8_arbiter
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    rr_mux8_arbiter_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [W-1:0]     mux_out;

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // One mux cell per data bit; column b gathers bit b of every source word.
    for (genvar b = 0; b < W; b++) begin : g_bit
        logic [N_REQ-1:0] col;
        for (genvar i = 0; i < N_REQ; i++) begin : g_src
            assign col[i] = bus.data_in[i*W + b];
        end
        mux_8_to_1_str u_mux (
            .d (col),
            .s (sel_q),
            .y (mux_out[b])
        );
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        done_d       = 1'b0;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_GRANT;
                    gnt_d      = onehot(pick_idx);
                    sel_d      = pick_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                // The word on the releasing edge is still captured.
                dout_d       = mux_out;
                dout_valid_d = 1'b1;
                hold_cnt_d   = hold_cnt_q + 8'd1;
                if (!bus.req[sel_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = busy_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Scoreboard bench for rr_mux8_arbiter: stimulus steps a tenure-level model and queues expected outputs,
// a monitor pops one entry per clock and compares every output.
module tb_rr_mux8_arbiter;
    import rr_mux8_arbiter_pkg::*;

    localparam int W        = 8;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [7:0]   gnt;
        logic [2:0]   sel;
        logic         busy;
        logic [W-1:0] dout;
        logic         dv;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rr_mux8_arbiter_if #(.W(W)) bus ();

    rr_mux8_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    // Reference model: a tenure owner, how many cycles it has held the mux, and the rotation start.
    bit           m_grant;
    int           m_owner;
    int           m_held;
    int           m_ptr;
    logic [W-1:0] m_dout;
    bit           m_dv;
    bit           m_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [8*W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_grant = 0;
        m_owner = 0;
        m_held  = 0;
        m_ptr   = 0;
        m_dout  = '0;
        m_dv    = 0;
        m_done  = 0;
    endtask

    // Called on a falling edge: drive inputs, predict the state after the next rising edge, wait a cycle.
    task automatic cyc(input logic [7:0] r, input logic [8*W-1:0] d);
        exp_t e;
        int   k;
        bus.req     = r;
        bus.data_in = d;
        m_done      = 0;
        if (m_grant) begin
            m_dout = d[m_owner*W +: W];
            m_dv   = 1;
            m_held = m_held + 1;
            if (!r[m_owner] || m_held == MAX_HOLD) begin
                m_grant = 0;
                m_ptr   = (m_owner + 1) % 8;
                m_done  = 1;
            end
        end else begin
            m_dv = 0;
            if (r != 8'h00) begin
                k = 0;
                while (!r[(m_ptr + k) % 8]) k++;
                m_owner = (m_ptr + k) % 8;
                m_grant = 1;
                m_held  = 0;
            end
        end
        e.gnt  = m_grant ? 8'(1 << m_owner) : 8'h00;
        e.sel  = 3'(m_owner);
        e.busy = m_grant;
        e.dout = m_dout;
        e.dv   = m_dv;
        e.done = m_done;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic [7:0] r, input int n);
        for (int i = 0; i < n; i++) cyc(r, rnd());
    endtask

    // Asynchronous reset checked between edges, then released on a falling edge.
    task automatic apply_reset(input logic [7:0] r);
        #2;
        rst     = 1'b1;
        bus.req = r;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dv", bus.dout_valid, 0);
        chk("rst_done", bus.done, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_dout", bus.dout, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_done_hold", bus.done, 0);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", bus.gnt, e.gnt);
                chk("sel", bus.sel, e.sel);
                chk("busy", bus.busy, e.busy);
                chk("dout_valid", bus.dout_valid, e.dv);
                chk("dout", bus.dout, e.dout);
                chk("done", bus.done, e.done);
            end
        end
    end

    initial begin : stimulus
        logic [8*W-1:0] d;
        logic [7:0]     r;
        bus.req     = '0;
        bus.data_in = '0;

        apply_reset(8'hFF);
        run(8'hFF, 3);
        run(8'h00, 3);

        // Single requester 3 holding the mux for three GRANT cycles with a fixed word.
        d          = rnd();
        d[24 +: 8] = 8'hA5;
        for (int i = 0; i < 3; i++) cyc(8'h08, d);
        cyc(8'h00, d);
        cyc(8'h00, d);
        run(8'h01, 2);
        run(8'h00, 3);

        // Two-way rotation and hold-limit preemption.
        run(8'h81, 40);
        run(8'h00, 6);
        run(8'h04, 22);
        run(8'h00, 6);

        // Leave ptr at 7, then 0 must beat 6; drop line 0 exactly on its hold-limit edge.
        for (int i = 0; i < 10 && !m_grant; i++) cyc(8'h40, rnd());
        cyc(8'h00, rnd());
        cyc(8'h41, rnd());
        for (int i = 0; i < 3 * MAX_HOLD && m_grant; i++)
            cyc((m_held == MAX_HOLD - 1) ? 8'h40 : 8'h41, rnd());
        run(8'h00, 3);

        // Reset in the middle of requester 5's tenure.
        for (int i = 0; i < 10 && !(m_grant && m_owner == 5); i++) cyc(8'h20, rnd());
        cyc(8'h20, rnd());
        apply_reset(8'h20);
        run(8'h20, 3);
        run(8'h00, 3);

        // Random request patterns: lines toggle occasionally so tenures end both ways.
        r = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r = r ^ 8'($urandom);
            cyc(r, rnd());
        end
        run(8'h00, 4);

        @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

endmodule
